// File: rtl/sram_dma_copy.sv
// sram_dma_copy: single-channel block-copy engine acting as AXI-Lite master on the 128-bit SRAM
// slave. It runs one read-then-write per 16-byte beat, strictly in order, with one outstanding
// transaction.
//
// Optional feature macro: FILL_MODE_EN. When defined, a start with i_fill_mode=1 writes
// i_fill_data to every destination beat and issues no reads.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   i_start             one-cycle request, only sampled while idle
//   i_src_addr          byte address of the first source beat
//   i_dst_addr          byte address of the first destination beat
//   i_num_beats         number of 16-byte beats to copy
//   i_fill_data         fill pattern (FILL_MODE_EN only)
//   i_fill_mode         selects fill instead of copy (FILL_MODE_EN only)
//   o_busy              high while a transfer is in progress, including the DONE cycle
//   o_done              one-cycle completion pulse
//   o_err               sticky error flag for non-zero write responses
//   o_readAddr_*, i_readData_*                         read address / read data channels
//   o_writeAddr_*, o_writeData_*, i_writeResp_*        write address / data / response channels
module sram_dma_copy #(
  parameter int unsigned LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [31:0]      i_src_addr,
  input  logic [31:0]      i_dst_addr,
  input  logic [LEN_W-1:0] i_num_beats,
  input  logic [127:0]     i_fill_data,
  input  logic             i_fill_mode,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [31:0]      o_readAddr_addr,
  output logic             o_readAddr_valid,
  input  logic             i_readAddr_ready,
  input  logic [127:0]     i_readData_data,
  input  logic             i_readData_valid,
  output logic             o_readData_ready,
  output logic [31:0]      o_writeAddr_addr,
  output logic             o_writeAddr_valid,
  input  logic             i_writeAddr_ready,
  output logic [127:0]     o_writeData_data,
  output logic [15:0]      o_writeData_strb,
  output logic             o_writeData_valid,
  input  logic             i_writeData_ready,
  input  logic [31:0]      i_writeResp_msg,
  input  logic             i_writeResp_valid,
  output logic             o_writeResp_ready
);

  typedef enum logic [2:0] {
    StIdle,
    StRaddr,
    StRdata,
    StWrite,
    StWresp,
    StDone
  } state_e;

  state_e r_state, w_state_d;

  logic [31:0]      r_raddr;
  logic [31:0]      r_waddr;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] r_idx;
  logic [127:0]     r_buf;
  logic             r_err;
  logic             r_aw_done;
  logic             r_w_done;

  logic             w_start_acc;
  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_aw_fin;
  logic             w_w_fin;
  logic             w_last;
  logic             w_fill_start;
  logic             w_fill;
  logic [127:0]     w_fill_data;

`ifdef FILL_MODE_EN
  logic r_fill;

  assign w_fill_start = i_fill_mode;
  assign w_fill       = r_fill;
  assign w_fill_data  = i_fill_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill <= 1'b0;
    end else if (w_start_acc) begin
      r_fill <= i_fill_mode;
    end
  end
`else
  logic w_unused;

  assign w_fill_start = 1'b0;
  assign w_fill       = 1'b0;
  assign w_fill_data  = '0;
  assign w_unused     = ^{i_fill_data, i_fill_mode};
`endif

  assign w_start_acc = (r_state == StIdle) && i_start;
  assign w_aw_hs     = (r_state == StWrite) && !r_aw_done && i_writeAddr_ready;
  assign w_w_hs      = (r_state == StWrite) && !r_w_done && i_writeData_ready;
  // A channel counts as finished if it handshook earlier or is handshaking now.
  assign w_aw_fin    = r_aw_done || w_aw_hs;
  assign w_w_fin     = r_w_done || w_w_hs;
  assign w_last      = (r_idx == r_count - LEN_W'(1));

  assign o_readAddr_addr  = r_raddr;
  assign o_writeAddr_addr = r_waddr;
  assign o_writeData_data = r_buf;
  assign o_writeData_strb = 16'hFFFF;
  assign o_err            = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d         = r_state;
    o_busy            = (r_state != StIdle);
    o_done            = 1'b0;
    o_readAddr_valid  = 1'b0;
    o_readData_ready  = 1'b0;
    o_writeAddr_valid = 1'b0;
    o_writeData_valid = 1'b0;
    o_writeResp_ready = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          if (i_num_beats == '0) begin
            w_state_d = StDone;
          end else if (w_fill_start) begin
            w_state_d = StWrite;
          end else begin
            w_state_d = StRaddr;
          end
        end
      end
      StRaddr: begin
        o_readAddr_valid = 1'b1;
        if (i_readAddr_ready) w_state_d = StRdata;
      end
      StRdata: begin
        o_readData_ready = 1'b1;
        if (i_readData_valid) w_state_d = StWrite;
      end
      StWrite: begin
        o_writeAddr_valid = !r_aw_done;
        o_writeData_valid = !r_w_done;
        if (w_aw_fin && w_w_fin) w_state_d = StWresp;
      end
      StWresp: begin
        o_writeResp_ready = 1'b1;
        if (i_writeResp_valid) begin
          if (w_last) begin
            w_state_d = StDone;
          end else if (w_fill) begin
            w_state_d = StWrite;
          end else begin
            w_state_d = StRaddr;
          end
        end
      end
      StDone: begin
        o_done    = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_raddr   <= '0;
      r_waddr   <= '0;
      r_count   <= '0;
      r_idx     <= '0;
      r_buf     <= '0;
      r_err     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_start_acc) begin
            r_raddr   <= i_src_addr;
            r_waddr   <= i_dst_addr;
            r_count   <= i_num_beats;
            r_idx     <= '0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            if (w_fill_start) r_buf <= w_fill_data;
          end
        end
        StRdata: begin
          if (i_readData_valid) r_buf <= i_readData_data;
        end
        StWrite: begin
          // Flags are cleared as the beat leaves WRITE so the next beat starts fresh.
          if (w_aw_fin && w_w_fin) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            r_aw_done <= w_aw_fin;
            r_w_done  <= w_w_fin;
          end
        end
        StWresp: begin
          if (i_writeResp_valid) begin
            if (i_writeResp_msg != 32'd0) r_err <= 1'b1;
            if (!w_last) begin
              r_idx   <= r_idx + LEN_W'(1);
              r_raddr <= r_raddr + 32'd16;
              r_waddr <= r_waddr + 32'd16;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_dma_copy.sv
// Self-checking bench for sram_dma_copy: a behavioural AXI-Lite SRAM slave, a byte-addressed
// memory model and a write scoreboard of expected {addr, data} per destination beat.
module tb_sram_dma_copy;

  logic         clk;
  logic         rst;
  logic         i_start;
  logic [31:0]  i_src_addr;
  logic [31:0]  i_dst_addr;
  logic [11:0]  i_num_beats;
  logic [127:0] i_fill_data;
  logic         i_fill_mode;
  logic         o_busy;
  logic         o_done;
  logic         o_err;
  logic [31:0]  o_readAddr_addr;
  logic         o_readAddr_valid;
  logic         i_readAddr_ready;
  logic [127:0] i_readData_data;
  logic         i_readData_valid;
  logic         o_readData_ready;
  logic [31:0]  o_writeAddr_addr;
  logic         o_writeAddr_valid;
  logic         i_writeAddr_ready;
  logic [127:0] o_writeData_data;
  logic [15:0]  o_writeData_strb;
  logic         o_writeData_valid;
  logic         i_writeData_ready;
  logic [31:0]  i_writeResp_msg;
  logic         i_writeResp_valid;
  logic         o_writeResp_ready;

  sram_dma_copy #(.LEN_W(12)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_start           (i_start),
    .i_src_addr        (i_src_addr),
    .i_dst_addr        (i_dst_addr),
    .i_num_beats       (i_num_beats),
    .i_fill_data       (i_fill_data),
    .i_fill_mode       (i_fill_mode),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_err             (o_err),
    .o_readAddr_addr   (o_readAddr_addr),
    .o_readAddr_valid  (o_readAddr_valid),
    .i_readAddr_ready  (i_readAddr_ready),
    .i_readData_data   (i_readData_data),
    .i_readData_valid  (i_readData_valid),
    .o_readData_ready  (o_readData_ready),
    .o_writeAddr_addr  (o_writeAddr_addr),
    .o_writeAddr_valid (o_writeAddr_valid),
    .i_writeAddr_ready (i_writeAddr_ready),
    .o_writeData_data  (o_writeData_data),
    .o_writeData_strb  (o_writeData_strb),
    .o_writeData_valid (o_writeData_valid),
    .i_writeData_ready (i_writeData_ready),
    .i_writeResp_msg   (i_writeResp_msg),
    .i_writeResp_valid (i_writeResp_valid),
    .o_writeResp_ready (o_writeResp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0]   mem [logic [31:0]];
  logic [159:0] exp_q[$];
  logic [159:0] obs_q[$];

  // Slave knobs and observation counters.
  int bp_delay   = 0;
  int err_beat   = -1;
  int n_reads    = 0;
  int n_writes   = 0;
  int aw_dup     = 0;
  int w_dup      = 0;
  int w_unstable = 0;
  int any_valid  = 0;
  int bad_strb   = 0;

  logic         got_aw, got_w, w_prev_v;
  logic [31:0]  cap_a;
  logic [127:0] cap_d, w_prev_d;
  int           wcnt;

  function automatic logic [127:0] rd_beat(input logic [31:0] a);
    logic [127:0] r;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      logic [31:0] x;
      x = a + 32'(b);
      if (mem.exists(x)) r[8*b +: 8] = mem[x];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      i_readData_valid  <= 1'b0;
      i_writeResp_valid <= 1'b0;
      i_writeData_ready <= (bp_delay == 0);
      got_aw   = 1'b0;
      got_w    = 1'b0;
      w_prev_v = 1'b0;
      wcnt     = 0;
    end else begin
      if (o_readAddr_valid || o_writeAddr_valid || o_writeData_valid) any_valid++;
      if (i_readData_valid && o_readData_ready) i_readData_valid <= 1'b0;
      if (o_readAddr_valid && i_readAddr_ready) begin
        i_readData_valid <= 1'b1;
        i_readData_data  <= rd_beat(o_readAddr_addr);
        n_reads++;
      end
      if (o_writeAddr_valid && got_aw) aw_dup++;
      if (o_writeData_valid && got_w) w_dup++;
      if (w_prev_v && (!o_writeData_valid || o_writeData_data !== w_prev_d)) w_unstable++;
      if (o_writeData_valid && o_writeData_strb !== 16'hFFFF) bad_strb++;
      w_prev_v = o_writeData_valid && !i_writeData_ready;
      w_prev_d = o_writeData_data;
      if (o_writeAddr_valid && i_writeAddr_ready) begin
        got_aw = 1'b1;
        cap_a  = o_writeAddr_addr;
      end
      if (o_writeData_valid && i_writeData_ready) begin
        got_w = 1'b1;
        cap_d = o_writeData_data;
      end
      if (bp_delay == 0) begin
        i_writeData_ready <= 1'b1;
      end else if (got_aw && !got_w) begin
        wcnt++;
        i_writeData_ready <= (wcnt >= bp_delay);
      end else begin
        wcnt = 0;
        i_writeData_ready <= 1'b0;
      end
      if (i_writeResp_valid && o_writeResp_ready) i_writeResp_valid <= 1'b0;
      if (got_aw && got_w) begin
        obs_q.push_back({cap_a, cap_d});
        for (int b = 0; b < 16; b++) mem[cap_a + 32'(b)] = cap_d[8*b +: 8];
        i_writeResp_valid <= 1'b1;
        i_writeResp_msg   <= (n_writes == err_beat) ? 32'h1 : 32'h0;
        n_writes++;
        got_aw = 1'b0;
        got_w  = 1'b0;
      end
    end
  end

  task automatic clear_stats();
    n_reads = 0; n_writes = 0; aw_dup = 0; w_dup = 0; w_unstable = 0; any_valid = 0;
    bad_strb = 0;
  endtask

  // Pushes expected beats, pulses start, then watches until 3 cycles past the first done.
  // lat is the cycle (1 = first cycle after the start edge) in which done was seen.
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [11:0] n,
                          input logic fm, input logic [127:0] fd, input int restart_at,
                          output int lat, output int dones, output int busy_cyc,
                          output logic err_at_done);
    for (int i = 0; i < int'(n); i++) begin
      logic [31:0] da;
      logic [31:0] sa;
      da = d + 32'(i) * 32'd16;
      sa = s + 32'(i) * 32'd16;
      exp_q.push_back({da, fm ? fd : rd_beat(sa)});
    end
    @(negedge clk);
    i_src_addr = s; i_dst_addr = d; i_num_beats = n; i_fill_mode = fm; i_fill_data = fd;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    lat = 0; dones = 0; busy_cyc = 0; err_at_done = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      if (c == restart_at) begin
        i_start = 1'b1; i_num_beats = 12'd7; i_src_addr = 32'h0; i_dst_addr = 32'h700;
      end else begin
        i_start = 1'b0;
      end
      if (o_busy) busy_cyc++;
      if (o_done) begin
        dones++;
        if (lat == 0) begin
          lat = c;
          err_at_done = o_err;
        end
      end
      if (lat != 0 && c >= lat + 3) break;
      @(negedge clk);
    end
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({o_busy, o_done, o_err} !== 3'b000) begin
      n_fails++; $display("FAIL reset_status: got %b want 000", {o_busy, o_done, o_err});
    end
    n_checks++;
    if ({o_readAddr_valid, o_readData_ready, o_writeAddr_valid, o_writeData_valid,
         o_writeResp_ready} !== 5'b0) begin
      n_fails++; $display("FAIL reset_handshake: some valid/ready high");
    end
    n_checks++;
    if (o_readAddr_addr !== 32'h0 || o_writeAddr_addr !== 32'h0) begin
      n_fails++; $display("FAIL reset_addr: got %h/%h want 0", o_readAddr_addr, o_writeAddr_addr);
    end
    n_checks++;
    if (o_writeData_data !== 128'h0) begin
      n_fails++; $display("FAIL reset_data: got %h want 0", o_writeData_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_copy();
    int lat, dones, busy_cyc;
    logic e;
    clear_stats();
    run_xfer(32'h0, 32'h100, 12'd4, 1'b0, '0, 0, lat, dones, busy_cyc, e);
    n_checks++;
    if (dones !== 1) begin n_fails++; $display("FAIL copy_done_count: got %0d want 1", dones); end
    n_checks++;
    if (lat !== 17) begin n_fails++; $display("FAIL copy_latency: got %0d want 17", lat); end
    n_checks++;
    if (e !== 1'b0) begin n_fails++; $display("FAIL copy_err: got %b want 0", e); end
    n_checks++;
    if (n_reads !== 4 || n_writes !== 4) begin
      n_fails++; $display("FAIL copy_counts: reads %0d writes %0d want 4/4", n_reads, n_writes);
    end
    n_checks++;
    if (bad_strb !== 0) begin n_fails++; $display("FAIL copy_strb: %0d bad strobes", bad_strb); end
    for (int k = 0; k < 64; k++) begin
      n_checks++;
      if (mem[32'h100 + 32'(k)] !== 8'(k)) begin
        n_fails++; $display("FAIL copy_byte[%0h]: got %h want %h", 32'h100 + k,
                            mem[32'h100 + 32'(k)], 8'(k));
      end
    end
    while (exp_q.size() > 0) begin
      logic [159:0] ex, ob;
      ex = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fails++; $display("FAIL copy_sb_missing: want %h", ex);
      end else begin
        ob = obs_q.pop_front();
        if (ob !== ex) begin n_fails++; $display("FAIL copy_sb: got %h want %h", ob, ex); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fails++; $display("FAIL copy_sb_extra: %0d unexpected writes", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_zero_beats();
    int lat, dones, busy_cyc;
    logic e;
    clear_stats();
    run_xfer(32'h0, 32'h600, 12'd0, 1'b0, '0, 0, lat, dones, busy_cyc, e);
    n_checks++;
    if (dones !== 1) begin n_fails++; $display("FAIL zero_done_count: got %0d want 1", dones); end
    n_checks++;
    if (lat !== 1) begin n_fails++; $display("FAIL zero_done_cycle: got %0d want 1", lat); end
    n_checks++;
    if (busy_cyc !== 1) begin n_fails++; $display("FAIL zero_busy: got %0d want 1", busy_cyc); end
    n_checks++;
    if (any_valid !== 0 || n_writes !== 0) begin
      n_fails++; $display("FAIL zero_no_axi: valid cycles %0d writes %0d want 0", any_valid,
                          n_writes);
    end
  endtask

  task automatic test_backpressure();
    int lat, dones, busy_cyc;
    logic e;
    clear_stats();
    bp_delay = 5;
    run_xfer(32'h40, 32'h300, 12'd2, 1'b0, '0, 0, lat, dones, busy_cyc, e);
    bp_delay = 0;
    n_checks++;
    if (dones !== 1) begin n_fails++; $display("FAIL bp_done_count: got %0d want 1", dones); end
    n_checks++;
    if (lat !== 19) begin n_fails++; $display("FAIL bp_latency: got %0d want 19", lat); end
    n_checks++;
    if (aw_dup !== 0 || w_dup !== 0) begin
      n_fails++; $display("FAIL bp_dup: aw %0d w %0d want 0/0", aw_dup, w_dup);
    end
    n_checks++;
    if (w_unstable !== 0) begin
      n_fails++; $display("FAIL bp_stable: got %0d unstable cycles want 0", w_unstable);
    end
    n_checks++;
    if (n_writes !== 2) begin n_fails++; $display("FAIL bp_writes: got %0d want 2", n_writes); end
    while (exp_q.size() > 0) begin
      logic [159:0] ex, ob;
      ex = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fails++; $display("FAIL bp_sb_missing: want %h", ex);
      end else begin
        ob = obs_q.pop_front();
        if (ob !== ex) begin n_fails++; $display("FAIL bp_sb: got %h want %h", ob, ex); end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_wrap_and_busy_start();
    int lat, dones, busy_cyc;
    logic e;
    int i;
    clear_stats();
    run_xfer(32'h200, 32'hFFFF_FFF0, 12'd2, 1'b0, '0, 3, lat, dones, busy_cyc, e);
    n_checks++;
    if (dones !== 1) begin n_fails++; $display("FAIL wrap_done_count: got %0d want 1", dones); end
    n_checks++;
    if (lat !== 9) begin n_fails++; $display("FAIL wrap_latency: got %0d want 9", lat); end
    n_checks++;
    if (n_writes !== 2 || n_reads !== 2) begin
      n_fails++; $display("FAIL wrap_counts: reads %0d writes %0d want 2/2", n_reads, n_writes);
    end
    i = 0;
    while (exp_q.size() > 0) begin
      logic [159:0] ex, ob;
      ex = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fails++; $display("FAIL wrap_sb_missing: want %h", ex);
      end else begin
        ob = obs_q.pop_front();
        if (ob !== ex) begin n_fails++; $display("FAIL wrap_sb: got %h want %h", ob, ex); end
        if (i == 1) begin
          n_checks++;
          if (ob[159:128] !== 32'h0) begin
            n_fails++; $display("FAIL wrap_addr: got %h want 00000000", ob[159:128]);
          end
        end
      end
      i++;
    end
    obs_q.delete();
  endtask

  task automatic test_err_response();
    int lat, dones, busy_cyc;
    logic e;
    clear_stats();
    err_beat = 1;
    run_xfer(32'h80, 32'h380, 12'd3, 1'b0, '0, 0, lat, dones, busy_cyc, e);
    err_beat = -1;
    n_checks++;
    if (e !== 1'b1) begin n_fails++; $display("FAIL err_set: got %b want 1", e); end
    n_checks++;
    if (o_err !== 1'b1) begin n_fails++; $display("FAIL err_sticky: got %b want 1", o_err); end
    n_checks++;
    if (n_writes !== 3) begin n_fails++; $display("FAIL err_writes: got %0d want 3", n_writes); end
    while (exp_q.size() > 0) begin
      logic [159:0] ex, ob;
      ex = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fails++; $display("FAIL err_sb_missing: want %h", ex);
      end else begin
        ob = obs_q.pop_front();
        if (ob !== ex) begin n_fails++; $display("FAIL err_sb: got %h want %h", ob, ex); end
      end
    end
    obs_q.delete();
    clear_stats();
    run_xfer(32'h90, 32'h3C0, 12'd1, 1'b0, '0, 0, lat, dones, busy_cyc, e);
    n_checks++;
    if (e !== 1'b0 || o_err !== 1'b0) begin
      n_fails++; $display("FAIL err_clear: got %b/%b want 0", e, o_err);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid_beat();
    int lat, dones, busy_cyc;
    logic e;
    bit seen;
    clear_stats();
    @(negedge clk);
    i_src_addr = 32'h0; i_dst_addr = 32'h400; i_num_beats = 12'd4; i_fill_mode = 1'b0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (o_writeAddr_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!seen) begin n_fails++; $display("FAIL rst_mid_reach_write: got 0 want 1"); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({o_busy, o_readAddr_valid, o_writeAddr_valid, o_writeData_valid, o_writeResp_ready,
         o_readData_ready, o_done} !== 7'b0) begin
      n_fails++; $display("FAIL rst_mid_async: busy/valid/ready not all 0");
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (n_writes !== 0) begin
      n_fails++; $display("FAIL rst_mid_partial: got %0d writes want 0", n_writes);
    end
    exp_q.delete();
    obs_q.delete();
    clear_stats();
    run_xfer(32'h0, 32'h400, 12'd4, 1'b0, '0, 0, lat, dones, busy_cyc, e);
    n_checks++;
    if (dones !== 1 || lat !== 17) begin
      n_fails++; $display("FAIL rst_mid_rerun: done %0d lat %0d want 1/17", dones, lat);
    end
    n_checks++;
    if (n_writes !== 4) begin n_fails++; $display("FAIL rst_mid_writes: got %0d want 4", n_writes);
    end
    while (exp_q.size() > 0) begin
      logic [159:0] ex, ob;
      ex = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fails++; $display("FAIL rst_mid_sb_missing: want %h", ex);
      end else begin
        ob = obs_q.pop_front();
        if (ob !== ex) begin n_fails++; $display("FAIL rst_mid_sb: got %h want %h", ob, ex); end
      end
    end
    obs_q.delete();
  endtask

`ifdef FILL_MODE_EN
  task automatic test_fill();
    int lat, dones, busy_cyc;
    logic e;
    logic [127:0] pat;
    pat = {16{8'hA5}};
    clear_stats();
    run_xfer(32'h0, 32'h500, 12'd3, 1'b1, pat, 0, lat, dones, busy_cyc, e);
    n_checks++;
    if (n_reads !== 0) begin n_fails++; $display("FAIL fill_reads: got %0d want 0", n_reads); end
    n_checks++;
    if (n_writes !== 3 || dones !== 1) begin
      n_fails++; $display("FAIL fill_writes: writes %0d done %0d want 3/1", n_writes, dones);
    end
    for (int k = 0; k < 48; k++) begin
      n_checks++;
      if (mem[32'h500 + 32'(k)] !== 8'hA5) begin
        n_fails++; $display("FAIL fill_byte[%0h]: got %h want a5", 32'h500 + k,
                            mem[32'h500 + 32'(k)]);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask
`endif

  initial begin
    rst = 1'b1;
    i_start = 1'b0; i_src_addr = '0; i_dst_addr = '0; i_num_beats = '0;
    i_fill_data = '0; i_fill_mode = 1'b0;
    i_readAddr_ready = 1'b1;
    i_writeAddr_ready = 1'b1;
    i_readData_data = '0;
    i_writeResp_msg = '0;
    for (int k = 0; k < 32'h400; k++) mem[32'(k)] = 8'(k);
    test_reset();
    test_copy();
    test_zero_beats();
    test_backpressure();
    test_wrap_and_busy_start();
    test_err_response();
    test_reset_mid_beat();
`ifdef FILL_MODE_EN
    test_fill();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
